// File: rtl/alarm_clock_pkg.sv
// alarm_clock_pkg: shared states, field limits and LED encodings for the alarm clock controller.
// The SNOOZE state exists only when ALARM_SNOOZE_EN is defined.
package alarm_clock_pkg;
   typedef enum logic [2:0] {
      S_RUN, S_SET_CLOCK, S_SET_ALARM, S_RINGING
`ifdef ALARM_SNOOZE_EN
      , S_SNOOZE
`endif
   } state_t;
   localparam logic [4:0] MAX_HOUR = 5'd23;
   localparam logic [5:0] MAX_MIN = 6'd59;
   localparam logic [5:0] MAX_SEC = 6'd59;
   localparam logic [1:0] LED_RUN = 2'b00;
   localparam logic [1:0] LED_SET_CLOCK = 2'b01;
   localparam logic [1:0] LED_SET_ALARM = 2'b10;
   localparam logic [1:0] LED_RING = 2'b11;
   function automatic logic [3:0] bcd_tens(input logic [5:0] v);
      return 4'(v / 6'd10);
   endfunction
   function automatic logic [3:0] bcd_units(input logic [5:0] v);
      return 4'(v % 6'd10);
   endfunction
endpackage

// File: rtl/alarm_clock_ctrl_if.sv
// alarm_clock_ctrl_if: switch/button inputs and display/buzzer/LED outputs of the alarm clock.
interface alarm_clock_ctrl_if;
   logic       sw_set_clock, sw_set_alarm, sw_alarm_en, btn_hours, btn_minutes;
   logic [3:0] digit3, digit2, digit1, digit0;
   logic       buzz;
   logic [1:0] leds;
   modport master (output sw_set_clock, sw_set_alarm, sw_alarm_en, btn_hours, btn_minutes,
                   input digit3, digit2, digit1, digit0, buzz, leds);
   modport slave (input sw_set_clock, sw_set_alarm, sw_alarm_en, btn_hours, btn_minutes,
                  output digit3, digit2, digit1, digit0, buzz, leds);
endinterface

// File: rtl/alarm_clock_ctrl_hhmm_counter.sv
// hhmm_counter: HH:MM register with button increments, minute-tick carry and BCD digit outputs.
module hhmm_counter
   import alarm_clock_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_inc_h,
   input  logic       i_inc_m,
   input  logic       i_tick,
   output logic [4:0] o_hh_nxt,
   output logic [5:0] o_mm_nxt,
   output logic [3:0] o_h_tens,
   output logic [3:0] o_h_units,
   output logic [3:0] o_m_tens,
   output logic [3:0] o_m_units
);
   logic [4:0] r_hh;
   logic [5:0] r_mm;
   logic       w_m_wrap, w_m_step, w_h_step;
   // only the running tick carries into hours; the minute button wraps alone
   always_comb begin
      w_m_wrap = r_mm == MAX_MIN;
      w_m_step = i_inc_m | i_tick;
      w_h_step = i_inc_h | (i_tick & w_m_wrap);
      o_mm_nxt = w_m_step ? (w_m_wrap ? 6'd0 : r_mm + 6'd1) : r_mm;
      o_hh_nxt = w_h_step ? (r_hh == MAX_HOUR ? 5'd0 : r_hh + 5'd1) : r_hh;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hh <= '0;
         r_mm <= '0;
      end else begin
         r_hh <= o_hh_nxt;
         r_mm <= o_mm_nxt;
      end
   end
   assign o_h_tens  = bcd_tens({1'b0, r_hh});
   assign o_h_units = bcd_units({1'b0, r_hh});
   assign o_m_tens  = bcd_tens(r_mm);
   assign o_m_units = bcd_units(r_mm);
endmodule

// File: rtl/alarm_clock_ctrl.sv
// alarm_clock_ctrl: time base, alarm setpoint and mode FSM driving BCD digits, buzzer and LEDs.
// Define ALARM_SNOOZE_EN to add the SNOOZE state (btn_minutes while ringing).
module alarm_clock_ctrl
   import alarm_clock_pkg::*;
#(
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int SNOOZE_MIN    = 5,
   parameter int RING_SEC      = 60
) (
   input logic clk,
   input logic reset,
   alarm_clock_ctrl_if.slave bus
);
   localparam int PW = $clog2(TICKS_PER_SEC);
   if (TICKS_PER_SEC < 2 || SNOOZE_MIN < 1 || SNOOZE_MIN > 59 || RING_SEC < 1 || RING_SEC > 255) begin : g_bad_param
      $error("alarm_clock_ctrl: parameter out of range");
   end
   state_t          r_state, w_nxt;
   logic [PW-1:0]   r_presc;
   logic [5:0]      r_sec;
   logic [7:0]      r_ring;
   logic            w_tick, w_min_tick, w_set_sw, w_trig, w_ring_done;
   logic [4:0]      w_t_hh_nxt, w_a_hh_nxt;
   logic [5:0]      w_t_mm_nxt, w_a_mm_nxt;
   logic [3:0][3:0] w_t_dig, w_a_dig;
`ifdef ALARM_SNOOZE_EN
   logic [11:0]     r_snz;
`endif
   always_comb begin
      w_set_sw    = bus.sw_set_clock | bus.sw_set_alarm;
      w_tick      = r_state != S_SET_CLOCK && r_presc == PW'(TICKS_PER_SEC - 1);
      w_min_tick  = w_tick && r_sec == MAX_SEC;
      w_trig      = r_state == S_RUN && bus.sw_alarm_en && w_min_tick &&
                    w_t_hh_nxt == w_a_hh_nxt && w_t_mm_nxt == w_a_mm_nxt;
      w_ring_done = w_tick && r_ring == 8'(RING_SEC - 1);
      w_nxt = bus.sw_set_clock ? S_SET_CLOCK : bus.sw_set_alarm ? S_SET_ALARM : w_trig ? S_RINGING : S_RUN;
      if (r_state == S_RINGING) begin
         w_nxt = S_RINGING;
`ifdef ALARM_SNOOZE_EN
         if (bus.btn_minutes) w_nxt = S_SNOOZE;
`endif
         if (!bus.sw_alarm_en || w_set_sw || w_ring_done) w_nxt = S_RUN;
      end
`ifdef ALARM_SNOOZE_EN
      if (r_state == S_SNOOZE)
         w_nxt = (!bus.sw_alarm_en || w_set_sw) ? S_RUN :
                 (w_tick && r_snz == 12'(SNOOZE_MIN * 60 - 1)) ? S_RINGING : S_SNOOZE;
`endif
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_RUN;
         r_presc <= '0;
         r_sec   <= '0;
         r_ring  <= '0;
      end else begin
         r_state <= w_nxt;
         r_presc <= (r_state == S_SET_CLOCK || w_tick) ? '0 : r_presc + PW'(1);
         r_sec   <= r_state == S_SET_CLOCK ? '0 : w_tick ? (r_sec == MAX_SEC ? '0 : r_sec + 6'd1) : r_sec;
         r_ring  <= r_state != S_RINGING ? '0 : r_ring + 8'(w_tick);
      end
   end
`ifdef ALARM_SNOOZE_EN
   always_ff @(posedge clk) begin
      if (reset) r_snz <= '0;
      else r_snz <= r_state != S_SNOOZE ? '0 : r_snz + 12'(w_tick);
   end
`endif
   hhmm_counter u_time (
      .clk, .reset,
      .i_inc_h(r_state == S_SET_CLOCK && bus.btn_hours),
      .i_inc_m(r_state == S_SET_CLOCK && bus.btn_minutes),
      .i_tick(w_min_tick),
      .o_hh_nxt(w_t_hh_nxt), .o_mm_nxt(w_t_mm_nxt),
      .o_h_tens(w_t_dig[3]), .o_h_units(w_t_dig[2]), .o_m_tens(w_t_dig[1]), .o_m_units(w_t_dig[0])
   );
   hhmm_counter u_alarm (
      .clk, .reset,
      .i_inc_h(r_state == S_SET_ALARM && bus.btn_hours),
      .i_inc_m(r_state == S_SET_ALARM && bus.btn_minutes),
      .i_tick(1'b0),
      .o_hh_nxt(w_a_hh_nxt), .o_mm_nxt(w_a_mm_nxt),
      .o_h_tens(w_a_dig[3]), .o_h_units(w_a_dig[2]), .o_m_tens(w_a_dig[1]), .o_m_units(w_a_dig[0])
   );
   assign {bus.digit3, bus.digit2, bus.digit1, bus.digit0} = r_state == S_SET_ALARM ? w_a_dig : w_t_dig;
   assign bus.buzz = r_state == S_RINGING && r_presc < PW'(TICKS_PER_SEC / 2);
   assign bus.leds = r_state == S_RUN ? LED_RUN : r_state == S_SET_CLOCK ? LED_SET_CLOCK :
                     r_state == S_SET_ALARM ? LED_SET_ALARM : LED_RING;
endmodule

// File: doc/alarm_clock_ctrl.md
# alarm_clock_ctrl

Hardware controller that sequences the alarm-clock datapath: keeps the HH:MM:SS time base, holds the alarm setpoint, and runs the mode state machine (run, set clock, set alarm, ringing). It consumes debounced switch levels and single-cycle button pulses and drives four BCD digits for the seven-segment decoders, the buzzer and the two mode LEDs. It sits between the board I/O synchronisers and the segment decoders, offloading timekeeping from the CPU.

## Interface
- TICKS_PER_SEC, 50_000_000, clk cycles per second (≥ 2)
- SNOOZE_MIN, 5, snooze length in minutes (1–59)
- RING_SEC, 60, auto-stop ring time in seconds (1–255)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- sw_set_clock  in  1  level, set-clock mode
- sw_set_alarm  in  1  level, set-alarm mode
- sw_alarm_en  in  1  level, alarm armed
- btn_hours  in  1  one-cycle pulse, increment hours
- btn_minutes  in  1  one-cycle pulse, increment minutes / snooze
- digit3..digit0  out  4 each  BCD H-tens, H-units, M-tens, M-units
- buzz  out  1  buzzer drive
- leds  out  2  mode: 00 RUN, 01 SET_CLOCK, 10 SET_ALARM, 11 RINGING/SNOOZE

## Operation
- States: RUN, SET_CLOCK, SET_ALARM, RINGING, SNOOZE (SNOOZE only with macro).
- Mode select each cycle from RUN/SET_*: sw_set_clock=1 → SET_CLOCK (priority); else sw_set_alarm=1 → SET_ALARM; else RUN.
- Prescaler counts 0..TICKS_PER_SEC-1; sec_tick on terminal count. Seconds 0–59, minutes 0–59 carry into hours 0–23; 23:59:59 + tick → 00:00:00.
- SET_CLOCK: prescaler and seconds held at 0; btn_hours increments hours (23→0), btn_minutes increments minutes (59→0, no hour carry). Both pulses same cycle: both fields increment.
- SET_ALARM: time keeps running; buttons edit alarm HH:MM with same wrap rules.
- Trigger: in RUN, sw_alarm_en=1, and the cycle seconds roll to 0 with HH:MM == alarm → RINGING. Editing never triggers.
- RINGING: buzz = 1 for first half of each second (prescaler < TICKS_PER_SEC/2), else 0. Exit to RUN when sw_alarm_en=0, either set switch rises, or RING_SEC seconds elapse.
- Display: SET_ALARM shows alarm HH:MM; all other states show time HH:MM.
- Buttons in RUN and RINGING (without macro) are ignored.

## Timing
- All outputs registered; a button pulse at cycle N is visible on digits at N+1.
- Trigger to buzz=1: 1 cycle (RINGING entered at edge after the rolling tick, buzz high the next cycle).
- Reset (any cycle, mid-ring or mid-edit): state RUN, time 00:00:00, alarm 00:00, prescaler 0, ring/snooze counters 0; digits 0,0,0,0; buzz 0; leds 00.
- Switch change takes effect on the next clock edge; no handshake.

## Configuration
- ALARM_SNOOZE_EN defined: btn_minutes in RINGING → SNOOZE (buzz 0, leds 11), re-enters RINGING after SNOOZE_MIN × 60 sec_ticks; sw_alarm_en=0 or a set switch in SNOOZE → RUN. Ring timer restarts on each re-entry.
- Undefined: no SNOOZE state; btn_minutes ignored in RINGING.

## Structure
- Package alarm_clock_pkg: state enum, MAX_HOUR=23, MAX_MIN=59, MAX_SEC=59, leds encodings.
- Sub-module hhmm_counter (hours/minutes register with increment and wrap, binary-to-BCD outputs), instantiated for time and for alarm.

## Test plan
- TICKS_PER_SEC=4; reset, set clock to 23:59 via 23 hour + 59 minute pulses, release, run 240 cycles → digits 0,0,0,0 after wrap through 00:00:00.
- Alarm 00:01, armed, time 00:00:00 → after 60 s, RINGING, leds 11, buzz 1 for 2 cycles, 0 for 2.
- RINGING with RING_SEC=3 → buzz 0, leds 00 after 3 s; separately sw_alarm_en=0 → RUN next cycle.
- sw_set_clock and sw_set_alarm both high → leds 01; btn_minutes at 00:59 → 00:00, hours unchanged.
- Reset asserted mid-RINGING → next cycle buzz 0, leds 00, digits 0000.
- ALARM_SNOOZE_EN, SNOOZE_MIN=1: btn_minutes while ringing → buzz 0 for 60 s, then RINGING again.
